// File: rtl/occupancy_grid_arbiter_pkg.sv
// rtl/occupancy_grid_arbiter_pkg.sv - shared types and defaults for the occupancy-grid arbiter
package occupancy_grid_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_UPD_READ,
    ST_UPD_WRITE
  } arb_state_t;

  localparam int CELL_BITS_DEF = 8;
  localparam int HIT_INC_DEF   = 4;
  localparam int MISS_DEC_DEF  = 1;

  typedef logic [CELL_BITS_DEF-1:0] cell_t;

endpackage

// File: rtl/occupancy_grid_arbiter_if.sv
// rtl/occupancy_grid_arbiter_if.sv - update, VGA and grid-RAM signals of the arbiter
interface occupancy_grid_arbiter_if #(
  parameter int XB = 6,
  parameter int YB = 6,
  parameter int AB = 12,
  parameter int CB = 8
);
  logic          upd_valid;
  logic          upd_ready;
  logic [XB-1:0] upd_x;
  logic [YB-1:0] upd_y;
  logic          upd_hit;
  logic          vga_req;
  logic [AB-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [CB-1:0] vga_rdata;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [CB-1:0] mem_wdata;
  logic [CB-1:0] mem_rdata;

  // Clients and the RAM sit on the master side; the arbiter is the slave.
  modport master (
    output upd_valid, upd_x, upd_y, upd_hit, vga_req, vga_addr, mem_rdata,
    input  upd_ready, vga_gnt, vga_rvalid, vga_rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  upd_valid, upd_x, upd_y, upd_hit, vga_req, vga_addr, mem_rdata,
    output upd_ready, vga_gnt, vga_rvalid, vga_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/occupancy_grid_arbiter_cell_update.sv
// rtl/occupancy_grid_arbiter_cell_update.sv - saturating log-odds hit/miss update of one cell
module occupancy_grid_arbiter_cell_update #(
  parameter int CELL_BITS = 8,
  parameter int HIT_INC   = 4,
  parameter int MISS_DEC  = 1
) (
  input  logic [CELL_BITS-1:0] cell_i,
  input  logic                 hit_i,
  output logic [CELL_BITS-1:0] cell_o
);
  localparam int WB       = CELL_BITS + 1;
  localparam int CELL_MAX = 2**CELL_BITS - 1;

  logic [WB-1:0] wide;
  logic [WB-1:0] sum;
  logic [WB-1:0] diff;

  // One extra bit catches both the carry out of a hit and the borrow of a miss.
  assign wide = {1'b0, cell_i};
  assign sum  = wide + WB'(HIT_INC);
  assign diff = wide - WB'(MISS_DEC);

  always_comb begin
    cell_o = '0;
    if (hit_i) begin
      cell_o = sum[CELL_BITS] ? CELL_BITS'(CELL_MAX) : sum[CELL_BITS-1:0];
    end else begin
      cell_o = diff[CELL_BITS] ? '0 : diff[CELL_BITS-1:0];
    end
  end
endmodule

// File: rtl/occupancy_grid_arbiter.sv
// rtl/occupancy_grid_arbiter.sv - shares the grid RAM between clear sweep, cell updates and VGA reads
module occupancy_grid_arbiter
  import occupancy_grid_arbiter_pkg::*;
#(
  parameter int GRID_WIDTH  = 64,
  parameter int GRID_HEIGHT = 64,
  parameter int CELL_BITS   = CELL_BITS_DEF,
  parameter int HIT_INC     = HIT_INC_DEF,
  parameter int MISS_DEC    = MISS_DEC_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      zero_occupancy_grid,
  output logic                      occupancy_busy,
  occupancy_grid_arbiter_if.slave   bus
);
  localparam int AB = $clog2(GRID_WIDTH * GRID_HEIGHT);
  localparam logic [AB-1:0] LAST_CELL = AB'(GRID_WIDTH * GRID_HEIGHT - 1);

  arb_state_t           state_q, state_d;
  logic [AB-1:0]        clr_cnt_q, clr_cnt_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 last_vga_q, last_vga_d;
  logic [AB-1:0]        addr_q, addr_d;
  logic                 hit_q, hit_d;
  logic                 rvalid_q;
  logic [AB-1:0]        upd_addr;
  logic                 upd_in_range;
  logic [CELL_BITS-1:0] new_cell;

  assign upd_addr     = AB'(int'(bus.upd_y) * GRID_WIDTH + int'(bus.upd_x));
  assign upd_in_range = (int'(bus.upd_x) < GRID_WIDTH) && (int'(bus.upd_y) < GRID_HEIGHT);

  occupancy_grid_arbiter_cell_update #(
    .CELL_BITS (CELL_BITS),
    .HIT_INC   (HIT_INC),
    .MISS_DEC  (MISS_DEC)
  ) u_cell_update (
    .cell_i (bus.mem_rdata),
    .hit_i  (hit_q),
    .cell_o (new_cell)
  );

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    clr_pend_d    = clr_pend_q;
    last_vga_d    = last_vga_q;
    addr_d        = addr_q;
    hit_d         = hit_q;
    bus.upd_ready = 1'b0;
    bus.vga_gnt   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q || zero_occupancy_grid) begin
          state_d = ST_CLEAR;
        end else if (bus.vga_req && (!bus.upd_valid || !last_vga_q)) begin
          bus.vga_gnt  = 1'b1;
          bus.mem_addr = bus.vga_addr;
          last_vga_d   = 1'b1;
        end else if (bus.upd_valid) begin
          // Out-of-range cells are consumed without touching the RAM.
          bus.upd_ready = 1'b1;
          last_vga_d    = 1'b0;
          if (upd_in_range) begin
            addr_d  = upd_addr;
            hit_d   = bus.upd_hit;
            state_d = ST_UPD_READ;
          end
        end
      end
      ST_CLEAR: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = clr_cnt_q;
        if (clr_cnt_q == LAST_CELL) begin
          clr_cnt_d  = '0;
          clr_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + AB'(1);
        end
      end
      ST_UPD_READ: begin
        bus.mem_addr = addr_q;
        if (zero_occupancy_grid) clr_pend_d = 1'b1;
        state_d = ST_UPD_WRITE;
      end
      ST_UPD_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = new_cell;
        if (zero_occupancy_grid) clr_pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_pend_q <= 1'b0;
      last_vga_q <= 1'b0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_pend_q <= clr_pend_d;
      last_vga_q <= last_vga_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      rvalid_q   <= bus.vga_gnt;
    end
  end

  assign bus.vga_rvalid = rvalid_q;
  assign bus.vga_rdata  = rvalid_q ? bus.mem_rdata : '0;
  assign occupancy_busy = (state_q != ST_IDLE) || clr_pend_q || zero_occupancy_grid;
endmodule

// File: tb/tb_occupancy_grid_arbiter.sv
// tb/tb_occupancy_grid_arbiter.sv - self-checking bench for occupancy_grid_arbiter
// A 5x3 grid exercises non-power-of-two bounds and lets both axes go out of range.
module tb_occupancy_grid_arbiter;
  localparam int W  = 5;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int XB = 3;
  localparam int YB = 2;
  localparam int AB = 4;
  localparam int CB = 8;

  logic clock = 1'b0;
  logic reset;
  logic zero;
  logic busy;

  occupancy_grid_arbiter_if #(.XB(XB), .YB(YB), .AB(AB), .CB(CB)) bus ();

  occupancy_grid_arbiter #(.GRID_WIDTH(W), .GRID_HEIGHT(H)) dut (
    .clock               (clock),
    .reset               (reset),
    .zero_occupancy_grid (zero),
    .occupancy_busy      (busy),
    .bus                 (bus)
  );

  always #5 clock = ~clock;

  logic [CB-1:0] ram [0:(1<<AB)-1];
  logic          pre_we;
  logic [AB-1:0] pre_addr;
  logic [CB-1:0] pre_data;

  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int num_checks = 0;
  int num_errors = 0;
  int ref_grid [N];
  bit m_last_vga;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cell(input int old, input bit hit);
    int v;
    if (hit) begin
      v = old + 4;
      if (v > 255) v = 255;
    end else begin
      v = old - 1;
      if (v < 0) v = 0;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    zero = 0; bus.upd_valid = 0; bus.upd_x = '0; bus.upd_y = '0; bus.upd_hit = 0;
    bus.vga_req = 0; bus.vga_addr = '0; pre_we = 0; pre_addr = '0; pre_data = '0;
  endtask

  task automatic poke(input int a, input int v);
    pre_we = 1; pre_addr = AB'(a); pre_data = CB'(v);
    tick();
    pre_we = 0;
    ref_grid[a] = v;
  endtask

  task automatic sweep();
    for (int i = 0; i < N; i++) begin
      tick();
      zero = 0; bus.vga_req = 0; bus.upd_valid = 0;
      @(negedge clock);
      check_eq("clr_we", bus.mem_we, 1);
      check_eq("clr_addr", bus.mem_addr, i);
      check_eq("clr_wdata", bus.mem_wdata, 0);
      check_eq("clr_busy", busy, 1);
      check_eq("clr_gnt", bus.vga_gnt, 0);
    end
    tick();
    @(negedge clock);
    check_eq("clr_end_busy", busy, 0);
    check_eq("clr_end_we", bus.mem_we, 0);
    for (int a = 0; a < N; a++) begin
      ref_grid[a] = 0;
      check_eq("clr_ram", ram[a], 0);
    end
  endtask

  task automatic run_clear();
    tick();
    zero = 1;
    @(negedge clock);
    check_eq("zero_busy", busy, 1);
    check_eq("zero_we", bus.mem_we, 0);
    sweep();
  endtask

  task automatic directed_update(input int x, input int y, input bit hit, input int pre, input int want);
    int a;
    a = y * W + x;
    poke(a, pre);
    tick();
    bus.upd_valid = 1; bus.upd_x = XB'(x); bus.upd_y = YB'(y); bus.upd_hit = hit;
    @(negedge clock);
    check_eq("du_ready", bus.upd_ready, 1);
    check_eq("du_busy0", busy, 0);
    tick();
    bus.upd_valid = 0;
    @(negedge clock);
    check_eq("du_rd", {bus.mem_we, bus.mem_addr}, {1'b0, AB'(a)});
    check_eq("du_busy1", busy, 1);
    tick();
    @(negedge clock);
    check_eq("du_wr", {bus.mem_we, bus.mem_addr}, {1'b1, AB'(a)});
    check_eq("du_wdata", bus.mem_wdata, want);
    tick();
    @(negedge clock);
    check_eq("du_idle", {busy, bus.mem_we}, 0);
    check_eq("du_ram", ram[a], want);
    ref_grid[a] = want;
    m_last_vga = 0;
  endtask

  task automatic out_of_range(input int x, input int y);
    tick();
    bus.upd_valid = 1; bus.upd_x = XB'(x); bus.upd_y = YB'(y); bus.upd_hit = 1;
    @(negedge clock);
    check_eq("oor_ready", bus.upd_ready, 1);
    check_eq("oor_we0", bus.mem_we, 0);
    tick();
    bus.upd_valid = 0;
    @(negedge clock);
    check_eq("oor_we1", bus.mem_we, 0);
    check_eq("oor_busy", busy, 0);
    m_last_vga = 0;
  endtask

  // Transaction-level reference: pending requests, round-robin winner, 2-cycle RMW.
  task automatic run_traffic(input int cycles, input int p_vga, input int p_upd);
    bit vga_pend = 0, upd_pend = 0, uh = 0, exp_rv = 0, m_hit = 0, exp_v, exp_u, drained;
    int va = 0, ux = 0, uy = 0, rmw_left = 0, m_addr = 0, exp_rdata = 0, nv;
    drained = 0;
    for (int c = 0; c < cycles + 20 && !drained; c++) begin
      tick();
      if (c < cycles && !vga_pend && $urandom_range(99) < p_vga) begin
        vga_pend = 1; va = $urandom_range(N - 1);
      end
      if (c < cycles && !upd_pend && $urandom_range(99) < p_upd) begin
        upd_pend = 1; ux = $urandom_range(7); uy = $urandom_range(3); uh = $urandom_range(1);
      end
      bus.vga_req = vga_pend; bus.vga_addr = AB'(va);
      bus.upd_valid = upd_pend; bus.upd_x = XB'(ux); bus.upd_y = YB'(uy); bus.upd_hit = uh;
      @(negedge clock);
      exp_v = 0; exp_u = 0;
      if (rmw_left == 2) begin
        check_eq("t_rd", {bus.mem_we, bus.mem_addr}, {1'b0, AB'(m_addr)});
      end else if (rmw_left == 1) begin
        nv = exp_cell(ref_grid[m_addr], m_hit);
        check_eq("t_wr", {bus.mem_we, bus.mem_addr}, {1'b1, AB'(m_addr)});
        check_eq("t_wdata", bus.mem_wdata, nv);
        ref_grid[m_addr] = nv;
      end else begin
        exp_v = vga_pend && (!upd_pend || !m_last_vga);
        exp_u = upd_pend && !exp_v;
      end
      check_eq("t_gnt", bus.vga_gnt, exp_v);
      check_eq("t_ready", bus.upd_ready, exp_u);
      check_eq("t_busy", busy, rmw_left != 0);
      check_eq("t_rvalid", bus.vga_rvalid, exp_rv);
      if (exp_rv) check_eq("t_rdata", bus.vga_rdata, exp_rdata);
      if (exp_v) check_eq("t_vga_addr", {bus.mem_we, bus.mem_addr}, {1'b0, AB'(va)});
      exp_rv = exp_v;
      if (exp_v) begin
        exp_rdata = ref_grid[va]; vga_pend = 0; m_last_vga = 1;
      end
      if (rmw_left > 0) rmw_left--;
      if (exp_u) begin
        upd_pend = 0; m_last_vga = 0;
        if (ux < W && uy < H) begin
          rmw_left = 2; m_addr = uy * W + ux; m_hit = uh;
        end
      end
      drained = (c >= cycles) && !vga_pend && !upd_pend && rmw_left == 0 && !exp_rv;
    end
    check_eq("t_drained", drained, 1);
    tick();
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_last_vga = 0;
    tick();
    tick();
    @(negedge clock);
    check_eq("rst_outs", {bus.upd_ready, bus.vga_gnt, bus.vga_rvalid, bus.mem_we, busy,
                          bus.mem_addr, bus.mem_wdata}, 0);
    tick();
    reset = 0;
    @(negedge clock);
    check_eq("rst_rel_busy", busy, 0);

    for (int a = 0; a < N; a++) poke(a, $urandom_range(1, 255));
    run_clear();

    directed_update(2, 1, 1, 10, 14);
    directed_update(4, 2, 1, 253, 255);
    directed_update(0, 0, 0, 0, 0);
    directed_update(3, 0, 1, 255, 255);
    directed_update(1, 1, 0, 1, 0);
    out_of_range(5, 0);
    out_of_range(7, 1);
    out_of_range(2, 3);

    run_traffic(40, 100, 100);
    run_traffic(400, 40, 40);

    // Clear request arriving mid read-modify-write.
    poke(11, 100);
    tick();
    bus.upd_valid = 1; bus.upd_x = XB'(1); bus.upd_y = YB'(2); bus.upd_hit = 1;
    @(negedge clock);
    check_eq("zr_ready", bus.upd_ready, 1);
    tick();
    bus.upd_valid = 0; zero = 1;
    @(negedge clock);
    check_eq("zr_rd", {busy, bus.mem_we, bus.mem_addr}, {2'b10, AB'(11)});
    tick();
    zero = 0;
    @(negedge clock);
    check_eq("zr_wr", {busy, bus.mem_we, bus.mem_addr}, {2'b11, AB'(11)});
    check_eq("zr_wdata", bus.mem_wdata, 104);
    tick();
    bus.vga_req = 1; bus.upd_valid = 1;
    @(negedge clock);
    check_eq("zr_pend", {busy, bus.mem_we, bus.vga_gnt, bus.upd_ready}, 4'b1000);
    check_eq("zr_ram", ram[11], 104);
    m_last_vga = 0;
    sweep();

    // Clear, VGA and update all requesting together.
    tick();
    zero = 1; bus.vga_req = 1; bus.vga_addr = AB'(3); bus.upd_valid = 1; bus.upd_x = '0;
    @(negedge clock);
    check_eq("all3", {busy, bus.mem_we, bus.vga_gnt, bus.upd_ready}, 4'b1000);
    sweep();

    run_traffic(100, 50, 50);

    // Reset in the middle of a sweep.
    tick();
    zero = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      zero = 0;
    end
    @(negedge clock);
    check_eq("mid_clr_we", bus.mem_we, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clock);
    check_eq("mid_rst", {busy, bus.mem_we, bus.vga_rvalid}, 0);
    m_last_vga = 0;
    run_clear();
    run_traffic(60, 60, 60);

    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end
endmodule
